// File: rtl/adc_scan_peak.sv
// Round-robin ADC channel scanner: requests one conversion per channel through
// the SPI master each period and keeps a per-channel max/min peak with its round index.
module adc_scan_peak #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned PERIOD   = 28'h001_0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              clear,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_ch,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_peak,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              upd,
  output logic [CH_W-1:0]   upd_ch,
  output logic [IDX_W-1:0]  round_idx,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [CH_W:0]    CH_NUM   = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_CMP  = 3'd3,
    S_NEXT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [TO_W-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [IDX_W-1:0]    round_q, round_d;
  logic                spi_start_q, spi_start_d;
  logic                upd_q, upd_d;
  logic [CH_W-1:0]     upd_ch_q, upd_ch_d;
  logic                terr_q, terr_d;
  logic [DATA_W-1:0]   peak_q [CHANNELS];
  logic [DATA_W-1:0]   peak_d [CHANNELS];
  logic [IDX_W-1:0]    idx_q  [CHANNELS];
  logic [IDX_W-1:0]    idx_d  [CHANNELS];
  logic [CHANNELS-1:0] valid_q, valid_d;

  logic tick_c;
  logic take_c;
  logic rd_ok_c;

  // Period timer: free-runs only while enabled, one tick per PERIOD cycles.
  always_comb begin
    cnt_d  = '0;
    tick_c = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Strict compares: ties keep the earliest round's peak.
  assign take_c = !valid_q[ch_q]
                  || (!mode && (sample_q > peak_q[ch_q]))
                  || ( mode && (sample_q < peak_q[ch_q]));

  // Scan sequencer and peak update.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    wait_d   = wait_q;
    sample_d = sample_q;
    round_d  = round_q;
    upd_d    = 1'b0;
    upd_ch_d = upd_ch_q;
    terr_d   = terr_q;
    peak_d   = peak_q;
    idx_d    = idx_q;
    valid_d  = valid_q;

    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          state_d = S_REQ;
          ch_d    = '0;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (spi_done) begin
          sample_d = spi_data;
          state_d  = S_CMP;
        end else if (wait_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_CMP: begin
        state_d = S_NEXT;
        if (take_c && !clear) begin
          peak_d[ch_q]  = sample_q;
          idx_d[ch_q]   = round_q;
          valid_d[ch_q] = 1'b1;
          upd_d         = 1'b1;
          upd_ch_d      = ch_q;
        end
      end
      S_NEXT: begin
        if (ch_q == CH_LAST) begin
          round_d = round_q + IDX_W'(1);
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear wins over the round increment and timeout flag; the handshake itself is untouched.
    if (clear) begin
      valid_d = '0;
      round_d = '0;
      terr_d  = 1'b0;
    end

    spi_start_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      wait_q      <= '0;
      sample_q    <= '0;
      round_q     <= '0;
      spi_start_q <= 1'b0;
      upd_q       <= 1'b0;
      upd_ch_q    <= '0;
      terr_q      <= 1'b0;
      peak_q      <= '{default: '0};
      idx_q       <= '{default: '0};
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      wait_q      <= wait_d;
      sample_q    <= sample_d;
      round_q     <= round_d;
      spi_start_q <= spi_start_d;
      upd_q       <= upd_d;
      upd_ch_q    <= upd_ch_d;
      terr_q      <= terr_d;
      peak_q      <= peak_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
    end
  end

  // Readback mux; out-of-range channels read as empty.
  assign rd_ok_c  = ({1'b0, rd_ch} < CH_NUM);
  assign rd_peak  = rd_ok_c ? peak_q[rd_ch] : '0;
  assign rd_idx   = rd_ok_c ? idx_q[rd_ch]  : '0;
  assign rd_valid = rd_ok_c ? valid_q[rd_ch] : 1'b0;

  assign spi_start   = spi_start_q;
  assign spi_ch      = ch_q;
  assign upd         = upd_q;
  assign upd_ch      = upd_ch_q;
  assign round_idx   = round_q;
  assign timeout_err = terr_q;

endmodule
